// File: rtl/lvds_tx_gearbox.sv
// lvds_tx_gearbox: 7-to-8 transmit gearbox for the 7:1 LVDS pixel link.
// Packs 7-bit lane words LSB-first into 8-bit serializer words, plus clock lane.
//
// Ports:
//   px_clk          pixel / serializer-word clock, rising edge
//   px_reset_n      asynchronous active-low reset
//   enable          start streaming; deassert to drain back to idle
//   px_data         DATA_LANES x 7-bit words, lane k at [7k+6:7k]
//   px_valid        px_data holds a new word
//   px_ready        a word (or idle stuffing) is consumed this cycle
//   tx_data         [7:0] clock lane, data lane k at [8k+15:8k+8]
//   tx_valid        tx_data holds a new serializer word
//   tx_busy         streaming or draining
//   underrun_count  saturating count of consumed cycles without px_valid
module lvds_tx_gearbox #(
    parameter logic [6:0] CLK_PATTERN = 7'b110_0011,
    parameter int         DATA_LANES  = 4,
    parameter logic [6:0] IDLE_WORD   = 7'h00
) (
    input  logic                        px_clk,
    input  logic                        px_reset_n,
    input  logic                        enable,
    input  logic [7*DATA_LANES-1:0]     px_data,
    input  logic                        px_valid,
    output logic                        px_ready,
    output logic [8*(DATA_LANES+1)-1:0] tx_data,
    output logic                        tx_valid,
    output logic                        tx_busy,
    output logic [15:0]                 underrun_count
);

    localparam int NL = DATA_LANES + 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    logic [1:0]            state;
    logic [3:0]            fill;
    logic [3:0]            fill_nxt;
    logic [3:0]            shift;
    logic [NL-1:0][14:0]   acc;
    logic [NL-1:0][14:0]   acc_nxt;
    logic [NL-1:0][6:0]    word;
    logic                  active;
    logic                  draining;
    logic                  last;
    logic                  consume;
    logic                  emit;

    always_comb begin
        active   = (state == ST_RUN) || (state == ST_DRAIN);
        draining = (state == ST_DRAIN) || ((state == ST_RUN) && !enable);
        // Drain completes only when exactly one byte is pending, so
        // nothing partially packed is ever dropped.
        last     = draining && (fill == 4'd8);
        consume  = active && !last;
        emit     = (fill >= 4'd8);
        shift    = emit ? (fill - 4'd8) : fill;
        fill_nxt = fill - (emit ? 4'd8 : 4'd0) + 4'd7;

        word[0] = CLK_PATTERN;
        for (int k = 0; k < DATA_LANES; k++) begin
            word[k+1] = px_valid ? px_data[7*k +: 7] : IDLE_WORD;
        end

        for (int l = 0; l < NL; l++) begin
            acc_nxt[l] = (emit ? (acc[l] >> 8) : acc[l])
                       | ({8'd0, word[l]} << shift);
        end
    end

    assign px_ready = consume;
    assign tx_busy  = active;

    always_ff @(posedge px_clk or negedge px_reset_n) begin
        if (!px_reset_n) begin
            state          <= ST_IDLE;
            fill           <= 4'd0;
            acc            <= '0;
            tx_data        <= '0;
            tx_valid       <= 1'b0;
            underrun_count <= 16'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    tx_valid <= 1'b0;
                    fill     <= 4'd0;
                    acc      <= '0;
                    if (enable) begin
                        state <= ST_RUN;
                    end
                end
                ST_RUN, ST_DRAIN: begin
                    tx_valid <= emit;
                    if (emit) begin
                        for (int l = 0; l < NL; l++) begin
                            tx_data[8*l +: 8] <= acc[l][7:0];
                        end
                    end
                    if (last) begin
                        fill  <= 4'd0;
                        acc   <= '0;
                        state <= ST_IDLE;
                    end else begin
                        fill <= fill_nxt;
                        acc  <= acc_nxt;
                        // Once a drain is requested it runs to completion.
                        if (!enable) begin
                            state <= ST_DRAIN;
                        end
                    end
                    if (consume && !px_valid && (underrun_count != 16'hFFFF)) begin
                        underrun_count <= underrun_count + 16'd1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/lvds_tx_gearbox.md
# lvds_tx_gearbox

Transmit-side 7-to-8 gearbox for the 7:1 LVDS pixel link. It takes 7-bit pixel words per data lane in the px_clk domain and packs them, LSB-first, into a continuous 8-bit-per-cycle serializer word stream. It also generates the matching clock lane from CLK_PATTERN, so a far-end receiver running the 8-to-7 alignment sequencer locks to it. It sits between the pixel source and the OSERDES/BUFGCE_DIV transmit clocking.

## Interface
- CLK_PATTERN, 7'b110_0011, 7-bit word stuffed into the clock lane on every accepted pixel
- DATA_LANES, 4, number of 7-bit data lanes (1..8)
- IDLE_WORD, 7'h00, data-lane word substituted on underrun
- px_clk  in  1  pixel/serializer-word clock; all logic on rising edge
- px_reset_n  in  1  reset, asynchronous assert, active-low
- enable  in  1  start/keep streaming; deassert requests a drain to idle
- px_data  in  7*DATA_LANES  lane k at [7k+6:7k]; bit 0 transmitted first
- px_valid  in  1  px_data holds a new word
- px_ready  out  1  word (or IDLE_WORD stuffing) consumed this cycle
- tx_data  out  8*(DATA_LANES+1)  [7:0] = clock lane; data lane k at [8k+15:8k+8]; bit 0 first
- tx_valid  out  1  tx_data holds a new serializer word
- tx_busy  out  1  state is RUN or DRAIN
- underrun_count  out  16  saturating count of RUN cycles with px_ready=1 and px_valid=0

## Operation
- States: IDLE, RUN, DRAIN. Reset → IDLE.
- IDLE: px_ready=0 and tx_valid=0. Accumulators and fill count F are cleared. When enable=1, move to RUN on the next edge.
- RUN: one word is consumed every cycle, so px_ready=1 except in the drain-entry cycle.
  - Data lanes take px_data when px_valid=1, otherwise IDLE_WORD and underrun_count+1 (holds at 16'hFFFF).
  - The clock lane always takes CLK_PATTERN.
- Per-edge update in RUN, identical for every lane, with a shared 4-bit F (0..14) and a 15-bit accumulator per lane:
  - emit = (F >= 8).
  - If emit, tx_data lane byte <= acc[7:0].
  - tx_valid <= emit.
  - acc <= (acc >> 8*emit) | (word << (F - 8*emit)).
  - F <= F - 8*emit + 7.
- Sequence of F from RUN entry: 0,7,14,13,12,11,10,9,8,7,14,… F never exceeds 14, so there is no overflow and no backpressure beyond the drain rule.
- Drain: when enable=0 in RUN and F==8:
  - px_ready=0 (combinational), and no word is consumed.
  - The last byte is emitted (tx_valid<=1) and F <= 0.
  - State → IDLE.
  - If enable=0 while F!=8, RUN continues until F==8, which takes at most 8 cycles.
- Stream boundary: serializer byte m carries stream bits 8m..8m+7, where the stream is the concatenation of consumed words, bit 0 first. The clock lane therefore repeats with period 56 bits (7 bytes).
- tx_data holds its last value when tx_valid=0.
- Reset mid-operation: all state returns to reset values immediately. Partially packed bits are discarded.

## Timing
- Reset values:
  - px_ready=0, tx_valid=0, tx_busy=0.
  - tx_data=0, underrun_count=0.
  - F=0, accumulators=0, state=IDLE.
- The enable rising edge is sampled at edge e. RUN begins at e+1, and the first px_ready=1 is in cycle e+1.
- Latency: the first tx_valid=1 appears after the 3rd RUN edge (consumed words 0,1,2). From then on there are exactly 7 tx_valid pulses per 8 consumed words. tx_valid=0 on the edge consuming word n with n≡1 (mod 8), n≥9.
- px_ready and the underrun decision are both evaluated in the same cycle. px_valid has no effect on the tx_valid cadence.
- tx_busy falls on the edge the DRAIN byte is emitted.

## Test plan
- Clock lane, DATA_LANES=1, CLK_PATTERN default, px_valid=1 continuous:
  - The clock-lane byte sequence is 0xE3, 0xF1, … with period 7 bytes.
  - F follows 0,7,14,13,12,11,10,9,8,7.
  - tx_valid=0 exactly once per 8 px_ready cycles.
- Data lane, px_data=7'h7F constant: every data-lane byte is 0xFF. With words 0x01, 0x02, 0x03: byte0=0x01, byte1=0xC1.
- Underrun: drop px_valid for 5 cycles mid-RUN.
  - underrun_count goes 0→5.
  - The data lane carries IDLE_WORD bits in exactly those 35 stream positions.
  - The clock-lane cadence is unbroken.
- Drain: deassert enable with F=11.
  - Three more words are consumed (F 11→10→9→8).
  - Then one px_ready=0 cycle with a final tx_valid=1, F=0, and tx_busy=0.
  - Re-enable restarts with F=0 and clock byte 0xE3.
- Reset: assert px_reset_n=0 asynchronously mid-RUN. All outputs reach reset values without a clock edge. After release, IDLE holds until enable=1.
- Saturation: 70000 underrun cycles → underrun_count=16'hFFFF and held.
